// File: rtl/alg2_pkg.sv
// Shared definitions for the board-level arithmetic blocks (multiplier and
// divider): default operand widths and the divider sequencing states.
package alg2_pkg;

  // Default operand widths, shared with the shift-add multiplier top.
  localparam int ALG2_WIDTH_N = 16;
  localparam int ALG2_WIDTH_D = 8;

  // Sequencing states of the restoring divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : alg2_pkg

// File: rtl/seq_divider_if.sv
// Operand/result handshake of the sequential divider. The master side
// issues start with operands; the slave side (the divider) returns status
// and results.
interface seq_divider_if
  import alg2_pkg::*;
#(
  parameter int WIDTH_N = ALG2_WIDTH_N,
  parameter int WIDTH_D = ALG2_WIDTH_D
);

  logic               start;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               busy;
  logic               done;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : seq_divider_if

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and emit the quotient bit.
module div_step #(
  parameter int WIDTH_D = 8
) (
  input  logic [WIDTH_D:0]   r_in,
  input  logic               q_msb,
  input  logic [WIDTH_D-1:0] d,
  output logic [WIDTH_D:0]   r_out,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] r_shift_s;
  logic [WIDTH_D:0]   r_diff_s;
  logic               r_ge_s;

  // Shift, compare and conditionally subtract. The partial remainder is
  // always below the divisor, so the widened top bit stays zero and the
  // low WIDTH_D+1 bits of the shifted value are the true trial remainder.
  always_comb begin
    r_shift_s = {r_in, q_msb};
    r_ge_s    = (r_shift_s >= {2'b00, d});
    r_diff_s  = r_shift_s[WIDTH_D:0] - {1'b0, d};
    if (r_ge_s) begin
      r_out = r_diff_s;
      q_bit = 1'b1;
    end else begin
      r_out = r_shift_s[WIDTH_D:0];
      q_bit = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential restoring divider: WIDTH_N-bit dividend by WIDTH_D-bit divisor,
// one quotient bit per clock. Divide-by-zero completes in a single cycle
// with an all-ones quotient and the dividend's low bits as remainder.
module seq_divider
  import alg2_pkg::*;
#(
  parameter int WIDTH_N = ALG2_WIDTH_N,
  parameter int WIDTH_D = ALG2_WIDTH_D
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH_N - 1);

  div_state_t          state_r, state_next_s;
  logic [WIDTH_N-1:0]  q_r, q_next_s;
  logic [WIDTH_D-1:0]  d_r, d_next_s;
  logic [WIDTH_D:0]    r_r, r_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [WIDTH_N-1:0]  quo_r, quo_next_s;
  logic [WIDTH_D-1:0]  rem_r, rem_next_s;
  logic                dbz_r, dbz_next_s;
  logic                busy_r, done_r;

  logic [WIDTH_D:0]    step_r_s;
  logic                step_qbit_s;

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r_in  (r_r),
    .q_msb (q_r[WIDTH_N-1]),
    .d     (d_r),
    .r_out (step_r_s),
    .q_bit (step_qbit_s)
  );

  // Next-state and datapath update; everything holds unless a rule below
  // fires, so results only move on a completion.
  always_comb begin
    state_next_s = state_r;
    q_next_s     = q_r;
    d_next_s     = d_r;
    r_next_s     = r_r;
    cnt_next_s   = cnt_r;
    quo_next_s   = quo_r;
    rem_next_s   = rem_r;
    dbz_next_s   = dbz_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            q_next_s     = bus.dividend;
            d_next_s     = bus.divisor;
            r_next_s     = '0;
            cnt_next_s   = '0;
            state_next_s = RUN;
          end else begin
            quo_next_s   = '1;
            rem_next_s   = bus.dividend[WIDTH_D-1:0];
            dbz_next_s   = 1'b1;
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        q_next_s   = {q_r[WIDTH_N-2:0], step_qbit_s};
        r_next_s   = step_r_s;
        cnt_next_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          quo_next_s   = {q_r[WIDTH_N-2:0], step_qbit_s};
          rem_next_s   = step_r_s[WIDTH_D-1:0];
          dbz_next_s   = 1'b0;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      q_r     <= '0;
      d_r     <= '0;
      r_r     <= '0;
      cnt_r   <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      q_r     <= q_next_s;
      d_r     <= d_next_s;
      r_r     <= r_next_s;
      cnt_r   <= cnt_next_s;
      quo_r   <= quo_next_s;
      rem_r   <= rem_next_s;
      dbz_r   <= dbz_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider with default widths.
module tb_seq_divider;
  import alg2_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   lat;
  int   bcyc;

  seq_divider_if #(.WIDTH_N(16), .WIDTH_D(8)) bus ();

  seq_divider #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation at the current falling edge; returns in cycle 1
  // after the accepting edge with start released.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the cycle index after the accept edge
  // at which done is seen (0 = never), bc counts busy cycles before it.
  task automatic wait_done(output int lt, output int bc);
    lt = 0;
    bc = 0;
    for (int i = 1; i <= 40; i++) begin
      chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        lt = i;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] q, input logic [7:0] r, input logic z);
    chk({tag, "_quo"}, {16'd0, bus.quotient}, {16'd0, q});
    chk({tag, "_rem"}, {24'd0, bus.remainder}, {24'd0, r});
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, z});
  endtask

  initial begin
    logic [15:0] rdvd;
    logic [7:0]  rdvs;
    logic [31:0] recon;
    n_chk  = 0;
    n_fail = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk_res("rst", 16'd0, 8'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 460 / 23 with full timing checks
    start_op(16'd460, 8'd23);
    wait_done(lat, bcyc);
    chk("t460_lat", lat, 32'd17);
    chk("t460_busy", bcyc, 32'd16);
    chk_res("t460", 16'd20, 8'd0, 1'b0);
    @(negedge clk);
    chk("t460_pulse", {31'd0, bus.done}, 32'd0);
    chk("t460_hold", {16'd0, bus.quotient}, 32'd20);

    // Further directed vectors
    start_op(16'd1000, 8'd7);
    wait_done(lat, bcyc);
    chk("t1000_lat", lat, 32'd17);
    chk_res("t1000", 16'd142, 8'd6, 1'b0);
    @(negedge clk);
    start_op(16'd10, 8'd20);
    wait_done(lat, bcyc);
    chk_res("t10", 16'd0, 8'd10, 1'b0);
    @(negedge clk);
    start_op(16'hFFFF, 8'hFF);
    wait_done(lat, bcyc);
    chk_res("tffff_ff", 16'h0101, 8'd0, 1'b0);
    @(negedge clk);
    start_op(16'hFFFF, 8'd1);
    wait_done(lat, bcyc);
    chk_res("tffff_1", 16'hFFFF, 8'd0, 1'b0);
    @(negedge clk);

    // Divide by zero
    start_op(16'd5, 8'd0);
    wait_done(lat, bcyc);
    chk("dbz_lat", lat, 32'd1);
    chk("dbz_busy", bcyc, 32'd0);
    chk_res("dbz", 16'hFFFF, 8'h05, 1'b1);
    @(negedge clk);
    chk("dbz_pulse", {31'd0, bus.done}, 32'd0);
    chk("dbz_hold", {31'd0, bus.div_by_zero}, 32'd1);

    // Start while busy is ignored; results of the first op survive
    start_op(16'd1000, 8'd7);
    repeat (4) @(negedge clk);
    start_op(16'd460, 8'd23);
    wait_done(lat, bcyc);
    chk("ign_lat", lat, 32'd12);
    chk_res("ign", 16'd142, 8'd6, 1'b0);

    // Back-to-back: start accepted in the done cycle
    start_op(16'd460, 8'd23);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_held", {16'd0, bus.quotient}, 32'd142);
    wait_done(lat, bcyc);
    chk("b2b_lat", lat, 32'd17);
    chk_res("b2b", 16'd20, 8'd0, 1'b0);
    @(negedge clk);

    // Reset mid-run
    start_op(16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_done", {31'd0, bus.done}, 32'd0);
    chk("mrst_state", {30'd0, dut.state_r}, {30'd0, IDLE});
    chk_res("mrst", 16'd0, 8'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    start_op(16'd460, 8'd23);
    wait_done(lat, bcyc);
    chk("post_rst_lat", lat, 32'd17);
    chk_res("post_rst", 16'd20, 8'd0, 1'b0);
    @(negedge clk);

    // Random operands, checked against the division identity
    for (int k = 0; k < 1000; k++) begin
      rdvd = 16'($urandom_range(0, 65535));
      rdvs = 8'($urandom_range(1, 255));
      start_op(rdvd, rdvs);
      wait_done(lat, bcyc);
      chk("rnd_lat", lat, 32'd17);
      recon = 32'(bus.quotient) * 32'(rdvs) + 32'(bus.remainder);
      chk("rnd_ident", recon, {16'd0, rdvd});
      chk("rnd_remlt", {31'd0, (bus.remainder < rdvs)}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
